// File: rtl/pc_seq_pkg.sv
// Shared definitions for the program-counter sequencer: opcode values,
// FSM state encoding and status field widths.
package pc_seq_pkg;

  localparam logic [7:0] OP_JMP  = 8'h81;
  localparam logic [7:0] OP_CALL = 8'h82;
  localparam logic [7:0] OP_RET  = 8'h83;
  localparam logic [7:0] OP_GOTO = 8'h84;
  localparam logic [7:0] OP_JZ   = 8'h85;
  localparam logic [7:0] OP_JNZ  = 8'h87;

  localparam int REDIRECT_W = 1;
  localparam int FAULT_W    = 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_EVAL   = 2'd1,
    S_UPDATE = 2'd2,
    S_FAULT  = 2'd3
  } pc_state_e;

  // 0x86 sits inside the range but is not a control-flow opcode.
  function automatic logic is_cf_op(input logic [7:0] op);
    return (op == OP_JMP) || (op == OP_CALL) || (op == OP_RET) ||
           (op == OP_GOTO) || (op == OP_JZ) || (op == OP_JNZ);
  endfunction

endpackage

// File: rtl/pc_sequencer_ret_stack.sv
// Return-address LIFO for CALL/RET. Entry count drives the sp output;
// push and pop are never requested in the same cycle.
module ret_stack #(
  parameter int W     = 16,
  parameter int DEPTH = 8
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic [W-1:0]               din_i,
  output logic [W-1:0]               top_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] ONE       = CW'(1);
  localparam logic [CW-1:0] DEPTH_CNT = CW'(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [CW-1:0] count_q, count_d;
  logic [AW-1:0] wr_idx, top_idx;

  assign wr_idx  = count_q[AW-1:0];
  assign top_idx = AW'(count_q - ONE);

  always_comb begin
    count_d = count_q;
    if (push_i)     count_d = count_q + ONE;
    else if (pop_i) count_d = count_q - ONE;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) count_q <= '0;
    else        count_q <= count_d;
  end

  // Contents need no reset: only entries below count_q are ever read.
  always_ff @(posedge clock) begin
    if (push_i) mem_q[wr_idx] <= din_i;
  end

  assign top_o   = mem_q[top_idx];
  assign full_o  = (count_q == DEPTH_CNT);
  assign empty_o = (count_q == '0);
  assign count_o = count_q;

endmodule

// File: rtl/pc_sequencer.sv
// Program counter and control-flow sequencer: advances pc on completed
// fetches and executes JMP/CALL/RET/GOTO/JZ/JNZ through IDLE->EVAL->UPDATE.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int              PC_W     = 16,
  parameter int              DEPTH    = 8,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [31:0]             ir,
  input  logic                    op_valid,
  input  logic                    zero_flag,
  input  logic                    pc_inc,
  output logic [PC_W-1:0]         pc,
  output logic                    busy,
  output logic [REDIRECT_W-1:0]   redirect,
  output logic [FAULT_W-1:0]      fault,
  output logic [$clog2(DEPTH):0]  sp
);

  localparam logic [PC_W-1:0] PC_ONE = PC_W'(1);

  pc_state_e       state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [7:0]      op_q, op_d;
  logic [PC_W-1:0] tgt_q, tgt_d;
  logic [15:0]     off_q, off_d;
  logic [PC_W-1:0] npc_q, npc_d;
  logic            taken_q, taken_d;
  logic            redirect_q, redirect_d;

  logic            stk_push, stk_pop, stk_full, stk_empty;
  logic [PC_W-1:0] stk_top;
  logic [31:0]     goto_ext;
  logic            unused_bits;

  // Offset is sign-extended to 32 bits, then truncated to the pc width.
  assign goto_ext    = {{16{off_q[15]}}, off_q};
  assign unused_bits = ^{ir, goto_ext};

  ret_stack #(.W(PC_W), .DEPTH(DEPTH)) u_ret_stack (
    .clock   (clock),
    .reset   (reset),
    .push_i  (stk_push),
    .pop_i   (stk_pop),
    .din_i   (pc_q),
    .top_o   (stk_top),
    .full_o  (stk_full),
    .empty_o (stk_empty),
    .count_o (sp)
  );

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    op_d       = op_q;
    tgt_d      = tgt_q;
    off_d      = off_q;
    npc_d      = npc_q;
    taken_d    = taken_q;
    redirect_d = 1'b0;
    stk_push   = 1'b0;
    stk_pop    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (pc_inc) pc_d = pc_q + PC_ONE;
        if (op_valid && is_cf_op(ir[31:24])) begin
          op_d    = ir[31:24];
          tgt_d   = ir[PC_W-1:0];
          off_d   = ir[15:0];
          state_d = S_EVAL;
        end
      end
      S_EVAL: begin
        taken_d = 1'b1;
        npc_d   = tgt_q;
        state_d = S_UPDATE;
        case (op_q)
          OP_CALL: if (stk_full) state_d = S_FAULT;
          OP_RET: begin
            if (stk_empty) state_d = S_FAULT;
            else           npc_d   = stk_top;
          end
          OP_GOTO: npc_d   = pc_q + goto_ext[PC_W-1:0];
          OP_JZ:   taken_d = zero_flag;
          OP_JNZ:  taken_d = !zero_flag;
          default: ;
        endcase
      end
      S_UPDATE: begin
        if (taken_q) pc_d = npc_q;
        redirect_d = taken_q;
        stk_push   = (op_q == OP_CALL);
        stk_pop    = (op_q == OP_RET);
        state_d    = S_IDLE;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      pc_q       <= RESET_PC;
      op_q       <= '0;
      tgt_q      <= '0;
      off_q      <= '0;
      npc_q      <= '0;
      taken_q    <= 1'b0;
      redirect_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      op_q       <= op_d;
      tgt_q      <= tgt_d;
      off_q      <= off_d;
      npc_q      <= npc_d;
      taken_q    <= taken_d;
      redirect_q <= redirect_d;
    end
  end

  assign pc       = pc_q;
  assign busy     = (state_q == S_EVAL) || (state_q == S_UPDATE);
  assign redirect = REDIRECT_W'(redirect_q);
  assign fault    = FAULT_W'(state_q == S_FAULT);

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

- Program-counter and control-flow sequencer for the 32-bit processor core.
- Owns the fetch address `pc` and advances it on each completed fetch.
- Executes the control-flow opcodes (JMP, CALL, RET, GOTO, JZ, JNZ) handed over by the control unit after DECODE, and keeps an internal return-address stack for CALL/RET.
- Sits between the control unit and the instruction memory address port; all arithmetic/logic opcodes pass through it untouched.

## Interface

Parameters:
- `PC_W`, 16: width of `pc` and of branch targets (taken from `ir[PC_W-1:0]`).
- `DEPTH`, 8: return-stack entries; must be a power of two, at least 2.
- `RESET_PC`, 0: value loaded into `pc` on reset.

Ports:
- `clock`  in  1  system clock, all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low.
- `ir`  in  32  current instruction word; opcode is `ir[31:24]`; only sampled in the `op_valid` cycle.
- `op_valid`  in  1  one-cycle strobe from the control unit in its DECODE cycle.
- `zero_flag`  in  1  ALU zero result; sampled in the EVAL cycle.
- `pc_inc`  in  1  fetch completed; advance `pc` by 1.
- `pc`  out  PC_W  current fetch address.
- `busy`  out  1  high in EVAL and UPDATE; the control unit must not assert `op_valid` while high.
- `redirect`  out  1  one-cycle pulse in the cycle after `pc` is loaded non-sequentially.
- `fault`  out  1  sticky stack overflow/underflow indication.
- `sp`  out  $clog2(DEPTH)+1  number of valid return-stack entries.

## Operation

Opcodes:
- JMP = 0x81: `pc` ← target.
- CALL = 0x82: push `pc`, then `pc` ← target.
- RET = 0x83: `pc` ← pop.
- GOTO = 0x84: `pc` ← `pc` + sign-extended `ir[15:0]`, modulo 2^PC_W.
- JZ = 0x85: `pc` ← target if `zero_flag` = 1, else unchanged.
- JNZ = 0x87: `pc` ← target if `zero_flag` = 0, else unchanged.
- Target = `ir[PC_W-1:0]`, absolute.
- Any other opcode with `op_valid`: ignored; FSM stays in IDLE.

FSM states:
- IDLE: on `op_valid` with a control-flow opcode, latch opcode and target, then go to EVAL.
- EVAL: sample `zero_flag`, compute the next pc and the stack action, check stack bounds, then go to UPDATE; on a bound error go to FAULT.
- UPDATE: write `pc`, push or pop, go to IDLE.
- FAULT: `pc` and stack frozen; the only exit is reset.

Rules:
- `pc_inc` in IDLE: `pc` ← `pc` + 1, wrapping from all-ones to 0. `pc_inc` is ignored in EVAL, UPDATE and FAULT.
- `pc_inc` and `op_valid` in the same IDLE cycle: the increment is applied at that edge. CALL pushes and GOTO adds to the incremented value.
- CALL pushes the value of `pc` as held at the UPDATE edge.
- Overflow: CALL with `sp` = DEPTH. Underflow: RET with `sp` = 0. Either one sets `fault`; `pc` and `sp` are unchanged.
- Not-taken JZ/JNZ: still passes through UPDATE; `redirect` stays low.

## Timing

- Reset values: `pc` = RESET_PC, `sp` = 0, `busy` = 0, `redirect` = 0, `fault` = 0, state IDLE. Stack contents are don't-care.
- Latency with `op_valid` at cycle N:
  - `busy` is high in cycles N+1 and N+2.
  - The new `pc` is visible from cycle N+3.
  - `redirect` is high in cycle N+3 only; it pulses for every taken branch, JMP, CALL, RET and GOTO.
- `fault` rises in cycle N+2 and holds until reset.
- Reset asserted mid-operation aborts immediately to the reset values; no partial push or pop survives.
- Outputs are registered; there are no combinational paths from inputs to outputs.

## Structure

- Package `pc_seq_pkg` holds:
  - the opcode constants (0x81–0x87), shared with the control unit decode;
  - the FSM state encoding IDLE/EVAL/UPDATE/FAULT;
  - the `redirect`/`fault` field widths.
- Sub-module `ret_stack`: LIFO, DEPTH × PC_W, with push/pop/full/empty outputs and a count output that drives `sp`. Push and pop are never asserted together.
- The top level contains the FSM, the pc register, and the target/offset adder.

## Test plan

- Reset, then 3 `pc_inc` pulses → `pc` = 3, `redirect` never asserted.
- `pc` = 0x0010, CALL target 0x0200, then RET → `pc` = 0x0200 with `sp` = 1, then `pc` = 0x0010 with `sp` = 0, one `redirect` pulse per call/return.
- JZ 0x0040 with `zero_flag` = 0 → `pc` unchanged, no `redirect`. The same instruction with `zero_flag` = 1 → `pc` = 0x0040.
- `pc` = 0x0005, GOTO offset 0xFFFA → `pc` = 0xFFFF. Then `pc_inc` → `pc` = 0x0000.
- 9 nested CALLs with DEPTH = 8 → after the 9th, `fault` = 1, `sp` = 8, `pc` frozen, `pc_inc` ignored. Reset clears all of it.
- `op_valid` + `pc_inc` together at `pc` = 0x0020 with CALL 0x0100 → stack top = 0x0021, `pc` = 0x0100. Reset asserted during EVAL → `pc` = RESET_PC, `sp` = 0.
